// File: rtl/core_step_ctrl.sv
`timescale 1ns/1ps
// core_step_ctrl: single-cycle clock-enable generator for the picoMIPS core (free-run, step, breakpoint, burst).
// Latency: a debounced key press gives an enable one cycle later; halt_i and mode changes suppress the enable in the same cycle.
// Backpressure: none; halt_i is the only stall and it overrides every mode immediately.
//
// Ports:
//   clk_i, rst_i      CLOCK_50 and synchronous active-high reset
//   mode_i            00 RUN, 01 STEP, 10 BRKPT, 11 BURST
//   div_i             divider terminal count (tick every div_i+1 cycles)
//   step_key_n_i      raw active-low push key (asynchronous, bouncy)
//   pc_i, bp_addr_i   core program address and breakpoint address
//   burst_len_i       enables per burst
//   halt_i            core halt flag
//   core_en_o         one-cycle core enable
//   running_o         high in RUN_ST and BURST_ST
//   bp_hit_o          high while parked on a breakpoint
//   en_count_o        total enables issued, wraps at 16 bits
//
// Optional build macro CORE_STEP_BP_MASK_EN adds bp_mask_i; the breakpoint then
// compares only the address bits selected by the mask (zero mask = break every tick).

module core_step_ctrl #(
   parameter int A         = 8,
   parameter int DIV_W     = 26,
   parameter int DB_CYCLES = 1000000,
   parameter int BURST_W   = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [1:0]         mode_i,
   input  logic [DIV_W-1:0]   div_i,
   input  logic               step_key_n_i,
   input  logic [A-1:0]       pc_i,
   input  logic [A-1:0]       bp_addr_i,
`ifdef CORE_STEP_BP_MASK_EN
   input  logic [A-1:0]       bp_mask_i,
`endif
   input  logic [BURST_W-1:0] burst_len_i,
   input  logic               halt_i,
   output logic               core_en_o,
   output logic               running_o,
   output logic               bp_hit_o,
   output logic [15:0]        en_count_o
);

   typedef enum logic [2:0] {
      WAIT_ST   = 3'd0,
      RUN_ST    = 3'd1,
      BRKRUN_ST = 3'd2,
      BREAK_ST  = 3'd3,
      BURST_ST  = 3'd4,
      HALT_ST   = 3'd5
   } state_t;

   localparam logic [1:0] MODE_RUN   = 2'b00;
   localparam logic [1:0] MODE_STEP  = 2'b01;
   localparam logic [1:0] MODE_BRK   = 2'b10;

   // Stability counter runs 0..DB_CYCLES-1 while the synchronised key differs
   // from the debounced level; the level flips on the last of those samples.
   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   // ------------------------------------------------------------------
   // Key synchroniser and debouncer
   // ------------------------------------------------------------------
   logic            key_s1_q, key_s2_q;
   logic            db_level_q, db_level_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            press;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         key_s1_q   <= 1'b1;
         key_s2_q   <= 1'b1;
         db_level_q <= 1'b1;
         db_cnt_q   <= '0;
      end else begin
         key_s1_q   <= step_key_n_i;
         key_s2_q   <= key_s1_q;
         db_level_q <= db_level_d;
         db_cnt_q   <= db_cnt_d;
      end
   end

   // Any sample equal to the current level restarts the count, so bounces
   // shorter than DB_CYCLES never reach the level register.
   always_comb begin
      db_level_d = db_level_q;
      db_cnt_d   = '0;
      press      = 1'b0;
      if (key_s2_q != db_level_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_level_d = key_s2_q;
            press      = ~key_s2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Control state
   // ------------------------------------------------------------------
   state_t             state_q, state_d;
   logic [1:0]         mode_q;
   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic               pend_q, pend_d;
   logic [15:0]        en_cnt_q;
   logic               en;
   logic               bp_hit;
   logic               mode_chg;
   logic               div_run;
   logic               tick;
   logic               bp_match;

   assign mode_chg = (mode_i != mode_q);

`ifdef CORE_STEP_BP_MASK_EN
   assign bp_match = ((pc_i & bp_mask_i) == (bp_addr_i & bp_mask_i));
`else
   assign bp_match = (pc_i == bp_addr_i);
`endif

   // Every running state is entered from a non-running one, and the counter
   // is held at zero outside them, so each entry starts a fresh period.
   assign div_run = (state_q == RUN_ST) || (state_q == BRKRUN_ST) || (state_q == BURST_ST);
   assign tick    = div_run && (div_cnt_q >= div_i);

   // The step-off enable after a breakpoint restarts the period so the next
   // divided tick cannot land on the very next cycle (unless div_i is 0).
   always_comb begin
      div_cnt_d = '0;
      if (div_run && !tick && !pend_q) begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      pend_d  = 1'b0;
      en      = 1'b0;
      bp_hit  = 1'b0;

      if (halt_i) begin
         state_d = HALT_ST;
         burst_d = '0;
      end else if (mode_chg) begin
         state_d = WAIT_ST;
         burst_d = '0;
      end else begin
         case (state_q)
            WAIT_ST: begin
               // pend_q carries a step request from the previous cycle's press.
               en = pend_q;
               case (mode_i)
                  MODE_RUN:  state_d = RUN_ST;
                  MODE_STEP: pend_d  = press;
                  MODE_BRK: begin
                     if (press) begin
                        state_d = BRKRUN_ST;
                     end
                  end
                  default: begin
                     if (press && (burst_len_i != '0)) begin
                        state_d = BURST_ST;
                        burst_d = burst_len_i;
                     end
                  end
               endcase
            end

            RUN_ST: begin
               en = tick;
            end

            BRKRUN_ST: begin
               if (pend_q) begin
                  // Step off the breakpoint without checking the address.
                  en = 1'b1;
               end else if (tick) begin
                  if (bp_match) begin
                     state_d = BREAK_ST;
                  end else begin
                     en = 1'b1;
                  end
               end
            end

            BREAK_ST: begin
               bp_hit = 1'b1;
               if (press) begin
                  state_d = BRKRUN_ST;
                  pend_d  = 1'b1;
               end
            end

            BURST_ST: begin
               if (tick) begin
                  en = 1'b1;
                  if (burst_q <= BURST_W'(1)) begin
                     state_d = WAIT_ST;
                     burst_d = '0;
                  end else begin
                     burst_d = burst_q - BURST_W'(1);
                  end
               end
            end

            HALT_ST: begin
               state_d = WAIT_ST;
            end

            default: begin
               state_d = WAIT_ST;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= WAIT_ST;
         mode_q    <= mode_i;
         div_cnt_q <= '0;
         burst_q   <= '0;
         pend_q    <= 1'b0;
         en_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_i;
         div_cnt_q <= div_cnt_d;
         burst_q   <= burst_d;
         pend_q    <= pend_d;
         en_cnt_q  <= en_cnt_q + {15'd0, core_en_o};
      end
   end

   assign core_en_o  = en & ~rst_i;
   assign running_o  = (state_q == RUN_ST) || (state_q == BURST_ST);
   assign bp_hit_o   = bp_hit;
   assign en_count_o = en_cnt_q;

endmodule

// File: tb/tb_core_step_ctrl.sv
`timescale 1ns/1ps
// tb_core_step_ctrl: directed bench for core_step_ctrl with a short debounce window.
// Inputs change and outputs are sampled on the falling clock edge.
// A tiny core model advances pc on every enable so breakpoints can be reached.

module tb_core_step_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  mode = 2'b01;
   logic [7:0]  div = 8'd0;
   logic        step_key_n = 1'b1;
   logic [7:0]  pc;
   logic        pc_clr = 1'b1;
   logic [7:0]  bp_addr = 8'd0;
   logic [7:0]  burst_len = 8'd0;
   logic        halt = 1'b0;
   logic        core_en;
   logic        running;
   logic        bp_hit;
   logic [15:0] en_count;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   // Core model: program address advances on each enable.
   always @(posedge clk) begin
      if (pc_clr) pc <= 8'd0;
      else if (core_en) pc <= pc + 8'd1;
   end

   core_step_ctrl #(
      .A(8), .DIV_W(8), .DB_CYCLES(4), .BURST_W(8)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .mode_i       (mode),
      .div_i        (div),
      .step_key_n_i (step_key_n),
      .pc_i         (pc),
      .bp_addr_i    (bp_addr),
`ifdef CORE_STEP_BP_MASK_EN
      .bp_mask_i    (8'hFF),
`endif
      .burst_len_i  (burst_len),
      .halt_i       (halt),
      .core_en_o    (core_en),
      .running_o    (running),
      .bp_hit_o     (bp_hit),
      .en_count_o   (en_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Bouncy press: three edges within one cycle, then low for 'hold' cycles,
   // then high for 'hold' cycles. Counts enables and the last gap between them.
   task automatic press_key(input int hold, output int cnt, output int gap);
      int last;
      last = -1;
      cnt  = 0;
      gap  = 0;
      step_key_n = 1'b0;
      #2 step_key_n = 1'b1;
      #2 step_key_n = 1'b0;
      for (int i = 0; i < 2 * hold; i++) begin
         @(negedge clk);
         if (core_en) begin
            if (last >= 0) gap = i - last;
            last = i;
            cnt++;
         end
         if (i == hold - 1) step_key_n = 1'b1;
      end
   endtask

   task automatic count_en(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (core_en) cnt++;
      end
   endtask

   initial begin
      int k;
      int first;
      int n;
      int cnt;
      int gap;
      logic [15:0] snap;

      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      rst = 1'b0;
      pc_clr = 1'b0;
      @(negedge clk);
      check("rst_core_en", core_en, 0);
      check("rst_running", running, 0);
      check("rst_bp_hit", bp_hit, 0);
      check("rst_en_count", en_count, 0);

      // ---------------- RUN, div 3 ----------------
      mode = 2'b00;
      div  = 8'd3;
      k = 0;
      while (!running && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("run_enter", running, 1);
      first = -1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         if (core_en) begin
            n++;
            if (first < 0) first = i;
         end
      end
      check("run_first_en_idx", first, 3);
      check("run_en_in_20", n, 5);
      @(negedge clk);
      check("run_en_count_5", en_count, 5);
      check("run_idle_after_tick", core_en, 0);

      // ---------------- div 0 then halt ----------------
      div = 8'd0;
      @(negedge clk);
      check("div0_en", core_en, 1);
      halt = 1'b1;
      @(negedge clk);
      check("halt_same_cycle_en", core_en, 0);
      @(negedge clk);
      check("halted_running", running, 0);
      halt = 1'b0;
      mode = 2'b01;
      repeat (3) @(negedge clk);

      // ---------------- STEP with bouncing key ----------------
      snap = en_count;
      press_key(10, cnt, gap);
      check("step_pulses", cnt, 1);
      check("step_en_count_delta", en_count - snap, 1);

      // ---------------- BRKPT ----------------
      mode = 2'b10;
      bp_addr = 8'h05;
      pc_clr = 1'b1;
      @(negedge clk);
      pc_clr = 1'b0;
      @(negedge clk);
      snap = en_count;
      press_key(15, cnt, gap);
      check("brk_en_before_hit", cnt, 5);
      check("brk_bp_hit", bp_hit, 1);
      check("brk_pc", pc, 5);
      check("brk_core_en_idle", core_en, 0);
      check("brk_en_count_delta", en_count - snap, 5);

      // Step off: one unconditional enable, then run to the new breakpoint.
      bp_addr = 8'h09;
      press_key(15, cnt, gap);
      check("stepoff_en", cnt, 4);
      check("stepoff_pc", pc, 9);
      check("stepoff_bp_hit", bp_hit, 1);

      // ---------------- BURST ----------------
      mode = 2'b11;
      div = 8'd1;
      burst_len = 8'd3;
      repeat (2) @(negedge clk);
      check("mode_chg_clears_bp_hit", bp_hit, 0);
      press_key(15, cnt, gap);
      check("burst_en", cnt, 3);
      check("burst_gap", gap, 2);
      check("burst_done_running", running, 0);

      burst_len = 8'd0;
      press_key(10, cnt, gap);
      check("burst_len0_en", cnt, 0);

      // ---------------- burst aborted by mode change ----------------
      burst_len = 8'd5;
      div = 8'd3;
      step_key_n = 1'b0;
      k = 0;
      while (!core_en && k < 30) begin
         @(negedge clk);
         k++;
      end
      check("abort_burst_started", core_en, 1);
      @(negedge clk);
      mode = 2'b01;
      count_en(20, cnt);
      check("abort_no_more_en", cnt, 0);
      step_key_n = 1'b1;
      repeat (10) @(negedge clk);

      // ---------------- reset mid-burst at en_count 7 ----------------
      rst = 1'b1;
      mode = 2'b11;
      burst_len = 8'd20;
      div = 8'd1;
      @(negedge clk);
      rst = 1'b0;
      step_key_n = 1'b0;
      k = 0;
      while (en_count != 16'd7 && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("cnt7_reached", en_count, 7);
      check("cnt7_running", running, 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst2_core_en", core_en, 0);
      check("rst2_running", running, 0);
      check("rst2_bp_hit", bp_hit, 0);
      check("rst2_en_count", en_count, 0);
      step_key_n = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/core_step_ctrl.md
Name: core_step_ctrl

Overview:
- Parametrised clock-enable controller for the picoMIPS core on the DE1-SoC.
- Replaces the fixed slow-clock divider and the SW[9] clock mux between KEY and divided clock.
- Generates a single-cycle core enable on CLOCK_50 in four modes: divided free-run, debounced single-step, run-to-breakpoint on program address, and N-instruction burst.
- Sits between board switches/keys and the core's enable; the core runs on CLOCK_50 throughout.

Parameters:
- A, 8, program address width; matches the core's prog_addr.
- DIV_W, 26, divider counter width.
- DB_CYCLES, 1000000, cycles the synchronised key must be stable to count as debounced.
- BURST_W, 8, burst length width.

Ports:
- clk_i  in  1  system clock (CLOCK_50).
- rst_i  in  1  synchronous active-high reset.
- mode_i  in  2  mode select: 00 RUN, 01 STEP, 10 BRKPT, 11 BURST.
- div_i  in  DIV_W  divider terminal count; tick period is div_i+1 cycles.
- step_key_n_i  in  1  raw asynchronous active-low push key.
- pc_i  in  A  current core program address.
- bp_addr_i  in  A  breakpoint address.
- burst_len_i  in  BURST_W  number of enables per burst.
- halt_i  in  1  core halt flag.
- core_en_o  out  1  one-cycle core clock enable.
- running_o  out  1  high in RUN_ST and BURST_ST.
- bp_hit_o  out  1  high while in BREAK_ST.
- en_count_o  out  16  total enables issued; wraps at 16 bits.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - core_en_o=0, running_o=0, bp_hit_o=0, en_count_o=0.
  - Divider count=0, burst count=0, debounce state=released.
  - State=WAIT_ST.
- Key path:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level changes only after DB_CYCLES consecutive equal samples.
  - press = one-cycle pulse on the debounced high-to-low transition. Exactly one press per physical press.
- Divider:
  - cnt increments each cycle; tick=1 when cnt>=div_i, then cnt returns to 0.
  - div_i=0 gives a tick every cycle.
  - Lowering div_i below cnt mid-count gives a tick on the next cycle.
  - The divider runs only in RUN_ST, BRKRUN_ST and BURST_ST. On entry to any of these, cnt=0.
- States: WAIT_ST, RUN_ST, BRKRUN_ST, BREAK_ST, BURST_ST, HALT_ST.
- WAIT_ST:
  - mode 00 -> RUN_ST immediately.
  - mode 01: press -> core_en_o=1 for the following cycle; stay in WAIT_ST.
  - mode 10: press -> BRKRUN_ST.
  - mode 11: press with burst_len_i!=0 -> BURST_ST, burst count loaded with burst_len_i.
  - mode 11: press with burst_len_i=0 -> no enable, stay in WAIT_ST.
- RUN_ST: core_en_o=tick.
- BRKRUN_ST:
  - On tick, if pc_i==bp_addr_i: core_en_o=0, go to BREAK_ST.
  - Otherwise core_en_o=1.
- BREAK_ST:
  - bp_hit_o=1.
  - press -> one unconditional core_en_o next cycle (steps off the breakpoint), then BRKRUN_ST.
- BURST_ST:
  - core_en_o=tick; count decrements per enable.
  - When the last enable issues, -> WAIT_ST.
  - burst_len_i changes during a burst are ignored.
- Enable counting: en_count_o increments on every core_en_o=1.
- Priority (highest first): rst_i, halt_i, mode change, press/tick.
- halt_i=1 in any state:
  - core_en_o=0 in the same cycle; state -> HALT_ST.
  - Leaves HALT_ST to WAIT_ST when halt_i=0.
- Mode change: mode_i differs from its registered copy -> WAIT_ST, burst count=0, bp_hit_o=0, no enable in that cycle.
- Enable spacing: core_en_o is never high on two consecutive cycles unless div_i=0 in RUN_ST, BRKRUN_ST or BURST_ST.

Optional Feature:
- Macro: CORE_STEP_BP_MASK_EN.
- Defined: adds input bp_mask_i [A-1:0]; breakpoint match becomes (pc_i & bp_mask_i)==(bp_addr_i & bp_mask_i). A zero mask breaks on every tick.
- Undefined: port absent; exact match only.

Test Plan:
- DB_CYCLES=4, mode 00, div_i=3 -> core_en_o high on exactly every 4th cycle; en_count_o=5 after 20 cycles.
- Mode 01, key bouncing 3 edges within 2 cycles then held low 10 cycles -> exactly one core_en_o pulse; en_count_o=1.
- Mode 10, div_i=0, bp_addr_i=8'h05, pc_i incrementing from 0 per enable:
  - 5 enables, then bp_hit_o=1 and core_en_o=0 with pc_i=5.
  - A press gives one enable, then running resumes.
- Mode 11, burst_len_i=3, div_i=1, press -> 3 enables 2 cycles apart, then WAIT_ST. burst_len_i=0 -> no enables.
- halt_i asserted mid-RUN_ST -> core_en_o=0 the same cycle. mode_i 00->01 during BURST_ST -> burst aborted, no further enables.
- rst_i asserted mid-BURST_ST with en_count_o=7 -> next cycle all outputs 0 and state WAIT_ST.
